din_syn_capture: RTL and testbench
==================================

Name: din_syn_capture

Overview:
- Receive side of the CLK/DIN/SYN serial pattern link driven by the pattern generator on the DE0 GPIO header.
- Oversamples the incoming serial clock, data and sync lines with the local clk_in and shifts each bit into a TOTAL_BITS-wide capture register.
- Checks frame length against the SYN marker and reports done or error.
- Used for loopback verification of generated control patterns and as a receive front end on a second board.

Parameters:
- TOTAL_BITS, 620, data bits per frame; SYN is expected on edge index TOTAL_BITS.
- CNT_W, 10, bit counter width; must satisfy 2^CNT_W > TOTAL_BITS.
- TIMEOUT, 1024, clk_in cycles allowed between serial clock edges while in SHIFT.

Ports:
- clk_in, input, 1, local system clock; ser_clk must be at most clk_in/4.
- rst_n, input, 1, asynchronous active-low reset.
- arm, input, 1, level-sampled; a rising edge arms the capture for one frame.
- ser_clk, input, 1, serial clock from the header; asynchronous to clk_in.
- ser_din, input, 1, serial data; transmitter updates it on the ser_clk falling edge.
- ser_syn, input, 1, frame sync; high during the edge after the last data bit.
- data_cap, output, TOTAL_BITS, captured frame; bit k holds the k-th received bit (LSB first).
- bit_cnt, output, CNT_W, number of data bits captured so far.
- busy, output, 1, high in WAIT or SHIFT.
- frame_done, output, 1, one-cycle pulse on a good frame.
- frame_err, output, 1, one-cycle pulse on a bad frame.
- err_code, output, 2, 00 none, 01 short, 10 overflow, 11 timeout; holds until next arm.

Behaviour:
- Reset values: all outputs 0, state IDLE, synchronizer and counter registers 0.
- Input sync: ser_clk, ser_din and ser_syn each pass through 2 flops; ser_clk gets a third history flop.
- Edge detect: a rising edge (edge_r) is sync2=1 and hist=0. ser_din and ser_syn are sampled from their sync2 stage on the edge_r cycle.
- Latency: a ser_clk rising edge at the pin reaches data_cap/bit_cnt within 3 clk_in cycles.
- IDLE:
  - arm rising edge -> clear data_cap, bit_cnt and err_code; go to WAIT.
  - Serial edges are ignored.
- WAIT:
  - No timeout.
  - First edge_r with syn=0 -> store din at data_cap[0], bit_cnt=1, go to SHIFT.
  - First edge_r with syn=1 -> short error (code 01).
- SHIFT:
  - edge_r with syn=0 and bit_cnt<TOTAL_BITS -> data_cap[bit_cnt]<=din, bit_cnt+=1, reload timeout counter.
  - edge_r with syn=1 and bit_cnt==TOTAL_BITS -> frame_done pulse next cycle, go to IDLE.
  - edge_r with syn=1 and bit_cnt<TOTAL_BITS -> frame_err, code 01.
  - edge_r with syn=0 and bit_cnt==TOTAL_BITS -> frame_err, code 10; data_cap is not written.
  - TIMEOUT cycles with no edge_r -> frame_err, code 11.
- Every error returns to IDLE. data_cap and bit_cnt hold their last values until the next arm.
- data_cap is stable when frame_done or frame_err asserts.
- arm edges seen while busy are ignored.
- Simultaneous events: an arm edge in the same cycle as a frame end is ignored. Timeout and edge_r in the same cycle: edge_r wins.
- Reset mid-frame clears everything immediately. The next frame needs a new arm.
- busy=1 exactly while the state is WAIT or SHIFT.

Optional Feature:
- Macro: DIN_SYN_CAPTURE_CMP_EN.
- When defined, the block adds these ports:
  - exp_reg, input, TOTAL_BITS, expected pattern.
  - mismatch, output, 1, set on frame_done if data_cap differs from exp_reg; cleared on arm.
  - mismatch_cnt, output, CNT_W, count of differing bits, computed one bit per clk_in cycle after frame_done.
  - cmp_busy, output, 1, high during that count; arm is ignored while cmp_busy=1.
- When undefined, none of these ports or registers exist and behaviour is exactly as above.

Test Plan:
- TOTAL_BITS=16: reset, arm, send 16 bits 0xA5C3 LSB first then one SYN edge, ser_clk=clk_in/8 -> data_cap=0xA5C3, bit_cnt=16, frame_done pulses once, err_code=00.
- Same setup, SYN on edge 10 -> frame_err, err_code=01, bit_cnt=10, busy=0.
- Same setup, 17 edges with SYN low -> frame_err on edge 17, err_code=10, data_cap keeps the first 16 bits.
- TIMEOUT=64, stop ser_clk after 5 bits -> frame_err 64 cycles after the last edge, err_code=11.
- rst_n low mid-frame at bit 7 -> all outputs 0 immediately. Edges before a new arm are ignored. Arm plus a full frame -> frame_done.
- DIN_SYN_CAPTURE_CMP_EN defined, exp_reg=0xA5C3, send 0xA5C2 -> mismatch=1, mismatch_cnt=1 after 16 cycles, cmp_busy then drops.

Source files
------------

// File: rtl/din_syn_capture.sv
// rtl/din_syn_capture.sv - CLK/DIN/SYN serial frame receiver; optional compare unit via DIN_SYN_CAPTURE_CMP_EN
module din_syn_capture #(
    parameter int TOTAL_BITS = 620,
    parameter int CNT_W      = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_clk_in,
    input  logic                  i_rst_n,
    input  logic                  i_arm,
    input  logic                  i_ser_clk,
    input  logic                  i_ser_din,
    input  logic                  i_ser_syn,
`ifdef DIN_SYN_CAPTURE_CMP_EN
    input  logic [TOTAL_BITS-1:0] i_exp_reg,
    output logic                  o_mismatch,
    output logic [CNT_W-1:0]      o_mismatch_cnt,
    output logic                  o_cmp_busy,
`endif
    output logic [TOTAL_BITS-1:0] o_data_cap,
    output logic [CNT_W-1:0]      o_bit_cnt,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_frame_err,
    output logic [1:0]            o_err_code
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]      LP_TOTAL    = CNT_W'(TOTAL_BITS);
    localparam logic [TMO_W-1:0]      LP_TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TOTAL_BITS-1:0] LP_ONE      = {{(TOTAL_BITS-1){1'b0}}, 1'b1};

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_SHORT    = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // synchronizer stages and edge history
    logic r_clk_s1;
    logic r_clk_s2;
    logic r_clk_hist;
    logic r_din_s1;
    logic r_din_s2;
    logic r_syn_s1;
    logic r_syn_s2;
    logic r_arm_d;

    // frame state
    state_t                  r_state;
    logic                    r_busy;
    logic [TOTAL_BITS-1:0]   r_data_cap;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_frame_done;
    logic                    r_frame_err;
    logic [1:0]              r_err_code;
    logic [TMO_W-1:0]        r_tmo_cnt;

    logic                    w_edge_r;
    logic                    w_arm_rise;
    logic                    w_arm_ok;
    logic                    w_full;
    logic                    w_tmo_hit;
    logic [TOTAL_BITS-1:0]   w_bit_mask;

    assign w_edge_r   = r_clk_s2 & ~r_clk_hist;
    assign w_arm_rise = i_arm & ~r_arm_d;
    assign w_full     = (r_bit_cnt == LP_TOTAL);
    assign w_tmo_hit  = (r_tmo_cnt == LP_TMO_LAST);
    assign w_bit_mask = LP_ONE << r_bit_cnt;

`ifdef DIN_SYN_CAPTURE_CMP_EN
    logic                    r_mismatch;
    logic [CNT_W-1:0]        r_mismatch_cnt;
    logic                    r_cmp_busy;
    logic [CNT_W-1:0]        r_cmp_idx;
    logic                    w_frame_good;
    logic                    w_cmp_diff;

    localparam logic [CNT_W-1:0] LP_LAST_IDX = CNT_W'(TOTAL_BITS - 1);

    // a new arm must wait until the bit count of the previous frame is finished
    assign w_arm_ok     = w_arm_rise & ~r_cmp_busy;
    assign w_frame_good = (r_state == ST_SHIFT) & w_edge_r & r_syn_s2 & w_full;
    assign w_cmp_diff   = |((r_data_cap ^ i_exp_reg) & (LP_ONE << r_cmp_idx));
`else
    assign w_arm_ok     = w_arm_rise;
`endif

    // two-flop synchronizers plus ser_clk history flop and arm edge history
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_hist <= 1'b0;
            r_din_s1   <= 1'b0;
            r_din_s2   <= 1'b0;
            r_syn_s1   <= 1'b0;
            r_syn_s2   <= 1'b0;
            r_arm_d    <= 1'b0;
        end else begin
            r_clk_s1   <= i_ser_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_hist <= r_clk_s2;
            r_din_s1   <= i_ser_din;
            r_din_s2   <= r_din_s1;
            r_syn_s1   <= i_ser_syn;
            r_syn_s2   <= r_syn_s1;
            r_arm_d    <= i_arm;
        end
    end

    // frame FSM: arm, shift bits on each serial rising edge, judge the frame on SYN
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_data_cap   <= '0;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_tmo_cnt    <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arm_ok) begin
                        r_data_cap <= '0;
                        r_bit_cnt  <= '0;
                        r_err_code <= ERR_NONE;
                        r_tmo_cnt  <= '0;
                        r_state    <= ST_WAIT;
                        r_busy     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_edge_r) begin
                        if (r_syn_s2) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_SHORT;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_data_cap[0] <= r_din_s2;
                            r_bit_cnt     <= CNT_W'(1);
                            r_tmo_cnt     <= '0;
                            r_state       <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_edge_r) begin
                        if (r_syn_s2) begin
                            if (w_full) begin
                                r_frame_done <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_err_code  <= ERR_SHORT;
                            end
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_full) begin
                            // one bit too many: keep the captured frame untouched
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_OVERFLOW;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_data_cap <= r_din_s2 ? (r_data_cap | w_bit_mask)
                                                   : (r_data_cap & ~w_bit_mask);
                            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                            r_tmo_cnt  <= '0;
                        end
                    end else if (w_tmo_hit) begin
                        r_frame_err <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIN_SYN_CAPTURE_CMP_EN
    // compare unit: flag any difference at frame end, then count differing bits one per cycle
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
            r_cmp_busy     <= 1'b0;
            r_cmp_idx      <= '0;
        end else if ((r_state == ST_IDLE) && w_arm_ok) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if (w_frame_good) begin
            r_mismatch     <= (r_data_cap != i_exp_reg);
            r_mismatch_cnt <= '0;
            r_cmp_busy     <= 1'b1;
            r_cmp_idx      <= '0;
        end else if (r_cmp_busy) begin
            r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(w_cmp_diff);
            if (r_cmp_idx == LP_LAST_IDX) begin
                r_cmp_busy <= 1'b0;
            end else begin
                r_cmp_idx <= r_cmp_idx + CNT_W'(1);
            end
        end
    end

    assign o_mismatch     = r_mismatch;
    assign o_mismatch_cnt = r_mismatch_cnt;
    assign o_cmp_busy     = r_cmp_busy;
`endif

    assign o_data_cap   = r_data_cap;
    assign o_bit_cnt    = r_bit_cnt;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_frame_err  = r_frame_err;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_din_syn_capture.sv
// tb/tb_din_syn_capture.sv - randomized self-checking bench for din_syn_capture (compare unit via DIN_SYN_CAPTURE_CMP_EN)
module tb_din_syn_capture;

    localparam int TB_BITS = 16;
    localparam int TB_CW   = 5;
    localparam int TB_TMO  = 64;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              arm     = 1'b0;
    logic              ser_clk = 1'b0;
    logic              ser_din = 1'b0;
    logic              ser_syn = 1'b0;
    logic [TB_BITS-1:0] data_cap;
    logic [TB_CW-1:0]   bit_cnt;
    logic              busy;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        err_code;
`ifdef DIN_SYN_CAPTURE_CMP_EN
    logic [TB_BITS-1:0] exp_reg = '0;
    logic              mismatch;
    logic [TB_CW-1:0]   mismatch_cnt;
    logic              cmp_busy;
`endif

    din_syn_capture #(
        .TOTAL_BITS (TB_BITS),
        .CNT_W      (TB_CW),
        .TIMEOUT    (TB_TMO)
    ) dut (
        .i_clk_in       (clk),
        .i_rst_n        (rst_n),
        .i_arm          (arm),
        .i_ser_clk      (ser_clk),
        .i_ser_din      (ser_din),
        .i_ser_syn      (ser_syn),
`ifdef DIN_SYN_CAPTURE_CMP_EN
        .i_exp_reg      (exp_reg),
        .o_mismatch     (mismatch),
        .o_mismatch_cnt (mismatch_cnt),
        .o_cmp_busy     (cmp_busy),
`endif
        .o_data_cap     (data_cap),
        .o_bit_cnt      (bit_cnt),
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_frame_err    (frame_err),
        .o_err_code     (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_evt = 0;

    // reference: what the receiver should hold, derived from the frame rules
    logic [TB_BITS-1:0] m_data   = '0;
    int                 m_cnt    = 0;
    logic [1:0]         m_code   = 2'b00;
    bit                 m_active = 1'b0;
    int                 done_exp  = 0;
    int                 err_exp   = 0;
    int                 done_seen = 0;
    int                 err_seen  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_arm();
        if (!m_active) begin
            m_active = 1'b1;
            m_data   = '0;
            m_cnt    = 0;
            m_code   = 2'b00;
        end
    endtask

    task automatic model_edge(input logic din, input logic syn);
        if (!m_active) return;
        if (!syn && m_cnt < TB_BITS) begin
            m_data[m_cnt] = din;
            m_cnt++;
        end else begin
            m_active = 1'b0;
            if (syn && m_cnt == TB_BITS) begin
                done_exp++;
            end else begin
                err_exp++;
                m_code = syn ? 2'b01 : 2'b10;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b0;
        tick();
        arm = 1'b1;
        model_arm();
        last_evt = cyc;
        tick();
    endtask

    // data/syn change with the falling edge, rising edge after 4 clk_in (ser_clk = clk_in/8)
    task automatic send_edge(input logic din, input logic syn, input int hold = 4);
        ser_clk = 1'b0;
        ser_din = din;
        ser_syn = syn;
        repeat (4) tick();
        ser_clk = 1'b1;
        model_edge(din, syn);
        last_evt = cyc;
        repeat (hold) tick();
    endtask

    task automatic line_idle();
        ser_clk = 1'b0;
        ser_syn = 1'b0;
        ser_din = 1'b0;
        repeat (24) tick();
    endtask

    // compare process: frame-end pulses and settled outputs against the reference
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (frame_done) begin
                    done_seen++;
                    chk("done_expected", 32'(done_seen <= done_exp), 32'd1);
                    chk("done_data", 32'(data_cap), 32'(m_data));
                    chk("done_cnt", 32'(bit_cnt), 32'(m_cnt));
                    chk("done_code", 32'(err_code), 32'd0);
                    chk("done_busy", 32'(busy), 32'd0);
                    chk("done_err_excl", 32'(frame_err), 32'd0);
                end
                if (frame_err) begin
                    err_seen++;
                    chk("err_expected", 32'(err_seen <= err_exp), 32'd1);
                    chk("err_data", 32'(data_cap), 32'(m_data));
                    chk("err_cnt", 32'(bit_cnt), 32'(m_cnt));
                    chk("err_code", 32'(err_code), 32'(m_code));
                    chk("err_busy", 32'(busy), 32'd0);
                end
                if (cyc - last_evt >= 4) begin
                    chk("st_data", 32'(data_cap), 32'(m_data));
                    chk("st_cnt", 32'(bit_cnt), 32'(m_cnt));
                    chk("st_code", 32'(err_code), 32'(m_code));
                    chk("st_busy", 32'(busy), 32'(m_active));
                    chk("st_done_cnt", 32'(done_seen), 32'(done_exp));
                    chk("st_err_cnt", 32'(err_seen), 32'(err_exp));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TB_BITS-1:0] w;
        int kind, n, t5, terr, base;

        repeat (3) tick();
        chk("rst_data", 32'(data_cap), 32'd0);
        chk("rst_cnt", 32'(bit_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        last_evt = cyc;
        repeat (4) tick();

        // good frame 0xA5C3
        w = 16'hA5C3;
        do_arm();
        for (int i = 0; i < TB_BITS; i++) send_edge(w[i], 1'b0);
        send_edge(1'b0, 1'b1);
        line_idle();
        chk("lit_good_model", 32'(m_data), 32'hA5C3);
        chk("lit_good_data", 32'(data_cap), 32'hA5C3);
        chk("lit_good_cnt", 32'(bit_cnt), 32'd16);
        chk("lit_good_code", 32'(err_code), 32'd0);
        chk("lit_good_pulses", 32'(done_seen), 32'd1);

        // SYN after 10 data bits
        w = 16'h5A3C;
        do_arm();
        for (int i = 0; i < 10; i++) send_edge(w[i], 1'b0);
        send_edge(1'b0, 1'b1);
        line_idle();
        chk("lit_short_code", 32'(err_code), 32'd1);
        chk("lit_short_cnt", 32'(bit_cnt), 32'd10);
        chk("lit_short_busy", 32'(busy), 32'd0);
        chk("lit_short_data", 32'(data_cap), 32'h023C);

        // 17 edges without SYN
        w = 16'h3C5A;
        do_arm();
        for (int i = 0; i < TB_BITS; i++) send_edge(w[i], 1'b0);
        send_edge(1'b1, 1'b0);
        line_idle();
        chk("lit_ovf_code", 32'(err_code), 32'd2);
        chk("lit_ovf_data", 32'(data_cap), 32'h3C5A);
        chk("lit_ovf_cnt", 32'(bit_cnt), 32'd16);

        // serial clock stops after 5 bits
        do_arm();
        for (int i = 0; i < 4; i++) send_edge(1'b1, 1'b0);
        send_edge(1'b0, 1'b0, 0);
        t5 = -1;
        terr = -1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == 3) ser_clk = 1'b0;
            if (t5 < 0 && bit_cnt == TB_CW'(5)) t5 = cyc;
            if (frame_err) begin
                terr = cyc;
                m_active = 1'b0;
                m_code = 2'b11;
                err_exp++;
                break;
            end
        end
        chk("tmo_seen", 32'(terr >= 0 && t5 >= 0), 32'd1);
        chk("tmo_latency", 32'(terr - t5), 32'd64);
        line_idle();
        chk("lit_tmo_code", 32'(err_code), 32'd3);
        chk("lit_tmo_cnt", 32'(bit_cnt), 32'd5);

        // reset in the middle of a frame
        do_arm();
        for (int i = 0; i < 7; i++) send_edge(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_cap), 32'd0);
        chk("mid_rst_cnt", 32'(bit_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_code", 32'(err_code), 32'd0);
        arm = 1'b0;
        ser_clk = 1'b0;
        m_active = 1'b0;
        m_data = '0;
        m_cnt = 0;
        m_code = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        last_evt = cyc;
        tick();
        for (int i = 0; i < 5; i++) send_edge(1'b1, 1'b0);
        line_idle();
        chk("unarmed_cnt", 32'(bit_cnt), 32'd0);
        chk("unarmed_busy", 32'(busy), 32'd0);
        base = done_seen;
        w = 16'($urandom);
        do_arm();
        for (int i = 0; i < TB_BITS; i++) send_edge(w[i], 1'b0);
        send_edge(1'b0, 1'b1);
        line_idle();
        chk("post_rst_done", 32'(done_seen - base), 32'd1);
        chk("post_rst_data", 32'(data_cap), 32'(w));

        // randomized frames, with ignored re-arms while busy
        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(0, 2);
            w = 16'($urandom);
            do_arm();
            n = (kind == 0) ? TB_BITS : (kind == 1) ? $urandom_range(0, TB_BITS - 1) : TB_BITS + 1;
            for (int i = 0; i < n; i++) begin
                send_edge((i < TB_BITS) ? w[i] : 1'($urandom), 1'b0);
                if (i < TB_BITS && $urandom_range(0, 7) == 0) begin
                    arm = 1'b0;
                    tick();
                    arm = 1'b1;
                    model_arm();
                    tick();
                end
            end
            if (kind != 2) send_edge(1'($urandom), 1'b1);
            line_idle();
        end

`ifdef DIN_SYN_CAPTURE_CMP_EN
        exp_reg = 16'hA5C3;
        w = 16'hA5C2;
        do_arm();
        chk("cmp_cleared", 32'(mismatch), 32'd0);
        for (int i = 0; i < TB_BITS; i++) send_edge(w[i], 1'b0);
        send_edge(1'b0, 1'b1, 0);
        t5 = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (frame_done) begin
                t5 = cyc;
                break;
            end
        end
        chk("cmp_done_seen", 32'(t5 >= 0), 32'd1);
        chk("cmp_busy_start", 32'(cmp_busy), 32'd1);
        terr = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!cmp_busy) begin
                terr = cyc;
                break;
            end
        end
        chk("cmp_busy_len", 32'(terr - t5), 32'd16);
        chk("cmp_mismatch", 32'(mismatch), 32'd1);
        chk("cmp_count", 32'(mismatch_cnt), 32'($countones(m_data ^ exp_reg)));
        chk("cmp_count_lit", 32'(mismatch_cnt), 32'd1);
        line_idle();
`endif

        repeat (10) tick();
        chk("final_done_total", 32'(done_seen), 32'(done_exp));
        chk("final_err_total", 32'(err_seen), 32'(err_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
